// File: rtl/pc_btb_fetch_pkg.sv
// Shared types and helpers for the fetch PC unit and its branch target buffer.
// Two-bit direction counters saturate at SNT and ST.
package pc_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic ctr_e sat_inc(input ctr_e c);
    return (c == ST) ? ST : ctr_e'(c + 2'd1);
  endfunction

  function automatic ctr_e sat_dec(input ctr_e c);
    return (c == SNT) ? SNT : ctr_e'(c - 2'd1);
  endfunction

endpackage

// File: rtl/pc_btb_fetch_btb_dm.sv
// Direct-mapped BTB: combinational lookup on rd_pc, one synchronous training write.
// Zero-cycle read latency; a write is visible to lookups from the next cycle on.
module btb_dm
  import pc_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int OFS       = 2,
  parameter int BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] rd_pc,
  output logic            rd_taken,
  output logic [XLEN-1:0] rd_target,
  input  logic            wr_vld,
  input  logic [XLEN-1:0] wr_pc,
  input  logic            wr_taken,
  input  logic [XLEN-1:0] wr_target
);

  localparam int IDX   = clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - OFS - IDX;

  logic [BTB_DEPTH-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag    [BTB_DEPTH];
  logic [XLEN-1:0]      r_target [BTB_DEPTH];
  ctr_e                 r_ctr    [BTB_DEPTH];

  logic [IDX-1:0]   w_rd_idx;
  logic [IDX-1:0]   w_wr_idx;
  logic [TAG_W-1:0] w_rd_tag;
  logic [TAG_W-1:0] w_wr_tag;
  logic             w_rd_hit;
  logic             w_wr_hit;
  logic             w_unused_ofs;

  assign w_rd_idx = rd_pc[OFS+IDX-1:OFS];
  assign w_rd_tag = rd_pc[XLEN-1:OFS+IDX];
  assign w_wr_idx = wr_pc[OFS+IDX-1:OFS];
  assign w_wr_tag = wr_pc[XLEN-1:OFS+IDX];

  // Byte-offset bits never take part in indexing or tagging.
  assign w_unused_ofs = ^{rd_pc[OFS-1:0], wr_pc[OFS-1:0]};

  assign w_rd_hit  = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
  assign w_wr_hit  = r_valid[w_wr_idx] && (r_tag[w_wr_idx] == w_wr_tag);
  assign rd_taken  = w_rd_hit && r_ctr[w_rd_idx][1];
  assign rd_target = rd_taken ? r_target[w_rd_idx] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= SNT;
      end
    end else if (wr_vld) begin
      if (w_wr_hit) begin
        r_ctr[w_wr_idx] <= wr_taken ? sat_inc(r_ctr[w_wr_idx]) : sat_dec(r_ctr[w_wr_idx]);
        if (wr_taken) begin
          r_target[w_wr_idx] <= wr_target;
        end
      end else if (wr_taken) begin
        // A taken miss evicts whatever aliased here and starts weakly taken.
        r_valid[w_wr_idx]  <= 1'b1;
        r_tag[w_wr_idx]    <= w_wr_tag;
        r_target[w_wr_idx] <= wr_target;
        r_ctr[w_wr_idx]    <= WT;
      end
    end
  end

endmodule

// File: rtl/pc_btb_fetch.sv
// Fetch PC register with next-PC priority redirect > stall > BTB > sequential, plus debug counters.
// PC updates every cycle; stall holds it, redirect always wins and is never back-pressured.
module pc_btb_fetch
  import pc_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter int              INST_BYTES = 4,
  parameter int              BTB_DEPTH  = 16,
  parameter int              CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             update_valid,
  input  logic [XLEN-1:0]  update_pc,
  input  logic             update_taken,
  input  logic [XLEN-1:0]  update_target,
  output logic [XLEN-1:0]  pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] redirect_count
);

  localparam int OFS = clog2(INST_BYTES);

  logic [XLEN-1:0]  r_pc;
  logic [CNT_W-1:0] r_fetch_cnt;
  logic [CNT_W-1:0] r_redir_cnt;
  logic [XLEN-1:0]  w_pc_next;
  logic             w_pred_taken;
  logic [XLEN-1:0]  w_pred_target;

  btb_dm #(
    .XLEN      (XLEN),
    .OFS       (OFS),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_pc     (r_pc),
    .rd_taken  (w_pred_taken),
    .rd_target (w_pred_target),
    .wr_vld    (update_valid),
    .wr_pc     (update_pc),
    .wr_taken  (update_taken),
    .wr_target (update_target)
  );

  always_comb begin
    w_pc_next = r_pc + XLEN'(INST_BYTES);
    if (redirect_valid) begin
      w_pc_next = redirect_pc;
    end else if (stall) begin
      w_pc_next = r_pc;
    end else if (w_pred_taken) begin
      w_pc_next = w_pred_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= RESET_VEC;
      r_fetch_cnt <= '0;
      r_redir_cnt <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (redirect_valid) begin
        r_redir_cnt <= r_redir_cnt + CNT_W'(1);
      end else if (!stall) begin
        r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
      end
    end
  end

  assign pc             = r_pc;
  assign pred_taken     = w_pred_taken;
  assign pred_target    = w_pred_target;
  assign fetch_count    = r_fetch_cnt;
  assign redirect_count = r_redir_cnt;

endmodule

// File: tb/tb_pc_btb_fetch.sv
// Bench for pc_btb_fetch: directed vectors checked against a table-based fetch/BTB model
// every cycle, plus literal expectations; a second instance covers a wrapping reset vector.
module tb_pc_btb_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] fetch_count;
  logic [31:0] redirect_count;

  logic [31:0] w_pc;
  logic        w_pred_taken;
  logic [31:0] w_pred_target;
  logic [31:0] w_fetch_count;
  logic [31:0] w_redirect_count;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 0;

  pc_btb_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .update_valid   (update_valid),
    .update_pc      (update_pc),
    .update_taken   (update_taken),
    .update_target  (update_target),
    .pc             (pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .fetch_count    (fetch_count),
    .redirect_count (redirect_count)
  );

  pc_btb_fetch #(.RESET_VEC(32'hFFFF_FFF8)) dut_w (
    .clk            (clk),
    .rst            (rst),
    .stall          (1'b0),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .update_valid   (1'b0),
    .update_pc      (32'h0),
    .update_taken   (1'b0),
    .update_target  (32'h0),
    .pc             (w_pc),
    .pred_taken     (w_pred_taken),
    .pred_target    (w_pred_target),
    .fetch_count    (w_fetch_count),
    .redirect_count (w_redirect_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a 16-entry table indexed by (pc/4)%16, tagged by pc/64, counters as 0..3.
  bit          m_v   [16];
  int unsigned m_tag [16];
  int unsigned m_tgt [16];
  int          m_ctr [16];
  int unsigned m_pc, m_fc, m_rc;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
    end
    m_pc = 0; m_fc = 0; m_rc = 0;
  endfunction

  function automatic bit m_hit(input int unsigned a);
    return m_v[(a / 4) % 16] && (m_tag[(a / 4) % 16] == a / 64);
  endfunction

  function automatic bit m_pt(input int unsigned a);
    return m_hit(a) && (m_ctr[(a / 4) % 16] >= 2);
  endfunction

  function automatic int unsigned m_ptgt(input int unsigned a);
    return m_pt(a) ? m_tgt[(a / 4) % 16] : 0;
  endfunction

  function automatic void model_step();
    int unsigned i;
    if (redirect_valid) begin
      m_pc = redirect_pc; m_rc = m_rc + 1;
    end else if (!stall) begin
      m_fc = m_fc + 1;
      m_pc = m_pt(m_pc) ? m_ptgt(m_pc) : m_pc + 4;
    end
    if (update_valid) begin
      i = (update_pc / 4) % 16;
      if (m_hit(update_pc)) begin
        if (update_taken) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = update_target;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (update_taken) begin
        m_v[i] = 1; m_tag[i] = update_pc / 64; m_tgt[i] = update_target; m_ctr[i] = 2;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (rst) model_reset();
    else     model_step();
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_pc",       64'(pc),             64'(m_pc));
      chk("model_pred",     64'(pred_taken),     64'(m_pt(m_pc)));
      chk("model_tgt",      64'(pred_target),    64'(m_ptgt(m_pc)));
      chk("model_fetch",    64'(fetch_count),    64'(m_fc));
      chk("model_redirect", 64'(redirect_count), 64'(m_rc));
    end
  end

  task automatic cyc(input bit s, input bit rv, input logic [31:0] rp,
                     input bit uv, input logic [31:0] up, input bit ut, input logic [31:0] ug);
    stall = s; redirect_valid = rv; redirect_pc = rp;
    update_valid = uv; update_pc = up; update_taken = ut; update_target = ug;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic jump(input logic [31:0] a);
    cyc(0, 1, a, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic train(input logic [31:0] a, input bit t, input logic [31:0] g);
    cyc(0, 0, 32'h0, 1, a, t, g);
  endtask

  initial begin
    #100000;
    n_errors++;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    rst = 1'b1;
    stall = 0; redirect_valid = 0; redirect_pc = 0;
    update_valid = 0; update_pc = 0; update_taken = 0; update_target = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1;
    chk("reset_pc",   64'(pc),          64'h0);
    chk("reset_pred", 64'(pred_taken),  64'h0);
    chk("reset_tgt",  64'(pred_target), 64'h0);

    repeat (4) idle();
    chk("seq_pc",    64'(pc),          64'h10);
    chk("seq_fetch", 64'(fetch_count), 64'd4);

    cyc(1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    cyc(1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    chk("stall_pc", 64'(pc), 64'h10);
    cyc(1, 1, 32'h40, 0, 32'h0, 0, 32'h0);
    chk("stall_redir_pc",    64'(pc),             64'h40);
    chk("stall_redir_count", 64'(redirect_count), 64'd1);
    chk("stall_redir_fetch", 64'(fetch_count),    64'd4);

    train(32'h8, 1, 32'h80);
    jump(32'h8);
    chk("btb_pred", 64'(pred_taken),  64'h1);
    chk("btb_tgt",  64'(pred_target), 64'h80);
    idle();
    chk("btb_follow_pc", 64'(pc), 64'h80);
    train(32'h8, 0, 32'h0);
    train(32'h8, 0, 32'h0);
    jump(32'h8);
    chk("btb_untrained", 64'(pred_taken), 64'h0);

    jump(32'h20);
    train(32'h20, 1, 32'h200);
    chk("same_cycle_pc", 64'(pc), 64'h24);
    jump(32'h20);
    chk("same_cycle_pred", 64'(pred_target), 64'h200);

    train(32'h8, 1, 32'h80);
    train(32'h8, 1, 32'h80);
    jump(32'h48);
    chk("alias_miss", 64'(pred_taken), 64'h0);
    train(32'h48, 1, 32'hC0);
    jump(32'h8);
    chk("alias_evicted", 64'(pred_taken), 64'h0);
    jump(32'h48);
    chk("alias_new_tgt", 64'(pred_target), 64'hC0);
    idle();
    chk("alias_follow_pc", 64'(pc), 64'hC0);

    repeat (3) train(32'h48, 1, 32'hC0);
    train(32'h48, 0, 32'h0);
    jump(32'h48);
    chk("sat_still_taken", 64'(pred_taken), 64'h1);

    jump(32'hFFFF_FFFC);
    idle();
    chk("wrap_main_pc", 64'(pc), 64'h0);

    train(32'h8, 1, 32'h80);
    #2;
    rst = 1'b1;
    model_reset();
    redirect_valid = 1; redirect_pc = 32'h100; update_valid = 1; update_pc = 32'h4;
    update_taken = 1; update_target = 32'h300;
    #1;
    chk("midrst_pc",       64'(pc),             64'h0);
    chk("midrst_pred",     64'(pred_taken),     64'h0);
    chk("midrst_fetch",    64'(fetch_count),    64'h0);
    chk("midrst_redirect", 64'(redirect_count), 64'h0);
    chk("midrst_wrap_pc",  64'(w_pc),           64'hFFFF_FFF8);
    @(posedge clk);
    @(negedge clk);
    chk("rst_held_pc", 64'(pc), 64'h0);
    rst = 1'b0;
    chk("wrap_pc0", 64'(w_pc), 64'hFFFF_FFF8);
    idle();
    chk("wrap_pc1", 64'(w_pc), 64'hFFFF_FFFC);
    chk("post_rst_pred4", 64'(pred_taken), 64'h0);
    idle();
    chk("wrap_pc2", 64'(w_pc), 64'h0);
    chk("post_rst_pc8", 64'(pc), 64'h8);
    chk("post_rst_pred8", 64'(pred_taken), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
